// File: rtl/sobel_frame_ctrl.sv
// ---------------------------------------------------------------------------
// sobel_frame_ctrl
//
// Frame-synchronous controller for the Sobel edge datapath.
//  - Debounces the mode pushbutton and steps the pending display mode
//    combined (00) -> Gx (01) -> Gy (10) -> combined on every press.
//  - Commits the pending mode to the absolute-value stage only at a frame
//    start, so one frame is always processed in a single mode.
//  - Counts nonzero edge pixels during a frame and publishes the count at
//    the frame end together with a one-cycle done strobe.
//
// Ports
//  iCLK        in   1      pixel clock (single clock domain)
//  iRST        in   1      asynchronous active-low reset
//  iKEY_n      in   1      raw mode pushbutton, active-low, asynchronous
//  iFVAL       in   1      frame valid from the capture path
//  iEdge       in   12     edge magnitude from the abs-value stage
//  iEdgeDVAL   in   1      iEdge valid strobe
//  oMode       out  2      committed mode: 00 comb, 01 Gx, 10 Gy
//  oPendMode   out  2      mode that commits at the next frame start
//  oEdgeCount  out  CNT_W  nonzero-edge pixel count of the last full frame
//  oFrameDone  out  1      one-cycle pulse when oEdgeCount updates
//  oInFrame    out  1      high while the controller is inside a frame
// ---------------------------------------------------------------------------
module sobel_frame_ctrl #(
    parameter int DEBOUNCE_CYC = 500000,
    parameter int CNT_W        = 22
) (
    input  logic             iCLK,
    input  logic             iRST,
    input  logic             iKEY_n,
    input  logic             iFVAL,
    input  logic [11:0]      iEdge,
    input  logic             iEdgeDVAL,
    output logic [1:0]       oMode,
    output logic [1:0]       oPendMode,
    output logic [CNT_W-1:0] oEdgeCount,
    output logic             oFrameDone,
    output logic             oInFrame
);

    // The debounce counter only ever holds 0 .. DEBOUNCE_CYC-1.
    localparam int DEB_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [DEB_W-1:0] DEB_LAST  = DEB_W'(DEBOUNCE_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        S_SYNC  = 2'd0,
        S_BLANK = 2'd1,
        S_FRAME = 2'd2
    } state_t;

    logic             key_s1;
    logic             key_s2;
    logic             key_acc;
    logic [DEB_W-1:0] deb_cnt;
    logic             press;

    state_t           state;
    logic             fv_d;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    logic             rise;
    logic             fall;
    logic             pix_hit;

    assign rise       = iFVAL & ~fv_d;
    assign fall       = ~iFVAL & fv_d;
    assign pix_hit    = iEdgeDVAL && (iEdge != 12'd0);
    // Saturating increment: a pathological frame pins at all-ones instead
    // of wrapping to a misleadingly small count.
    assign count_next = (pix_hit && (count != CNT_MAX)) ? count + CNT_W'(1) : count;

    // Key path. The synchronised level must differ from the accepted level
    // for DEBOUNCE_CYC consecutive samples before it is taken; any sample
    // back at the accepted level restarts the count, which filters bounce.
    // Only an accepted low level is a press, so holding the key produces a
    // single step. The press is registered, so the pending mode moves one
    // cycle after acceptance.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            key_s1    <= 1'b1;
            key_s2    <= 1'b1;
            key_acc   <= 1'b1;
            deb_cnt   <= '0;
            press     <= 1'b0;
            oPendMode <= 2'b00;
        end else begin
            key_s1 <= iKEY_n;
            key_s2 <= key_s1;
            press  <= 1'b0;

            if (press) begin
                oPendMode <= (oPendMode == 2'b10) ? 2'b00 : oPendMode + 2'b01;
            end

            if (key_s2 == key_acc) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DEB_LAST) begin
                key_acc <= key_s2;
                deb_cnt <= '0;
                press   <= ~key_s2;
            end else begin
                deb_cnt <= deb_cnt + DEB_W'(1);
            end
        end
    end

    // Frame FSM. After reset it waits for a blank so a frame already in
    // progress is never counted. The commit at the frame start samples the
    // registered pending mode, so a press landing on that very cycle is
    // deferred to the following frame.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            state      <= S_SYNC;
            fv_d       <= 1'b0;
            count      <= '0;
            oMode      <= 2'b00;
            oEdgeCount <= '0;
            oFrameDone <= 1'b0;
            oInFrame   <= 1'b0;
        end else begin
            fv_d       <= iFVAL;
            oFrameDone <= 1'b0;

            case (state)
                S_SYNC: begin
                    if (!iFVAL) begin
                        state <= S_BLANK;
                    end
                end
                S_BLANK: begin
                    if (rise) begin
                        state    <= S_FRAME;
                        oInFrame <= 1'b1;
                        oMode    <= oPendMode;
                        count    <= '0;
                    end
                end
                S_FRAME: begin
                    count <= count_next;
                    // The fall cycle's own pixel is included in the result.
                    if (fall) begin
                        state      <= S_BLANK;
                        oInFrame   <= 1'b0;
                        oEdgeCount <= count_next;
                        oFrameDone <= 1'b1;
                    end
                end
                default: begin
                    state    <= S_SYNC;
                    oInFrame <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sobel_frame_ctrl
//
// Self-checking bench for sobel_frame_ctrl with DEBOUNCE_CYC=4, CNT_W=4.
// Inputs are driven just after each falling edge; every cycle all outputs
// are compared with a behavioural model that works from key sample history
// and whole-frame pixel tallies. Directed scenarios add explicit checks of
// the values expected at notable points, followed by a randomized run.
// ---------------------------------------------------------------------------
module tb_sobel_frame_ctrl;

    localparam int DEB   = 4;
    localparam int CW    = 4;
    localparam int SAT   = (1 << CW) - 1;

    logic          iCLK = 1'b0;
    logic          iRST;
    logic          iKEY_n;
    logic          iFVAL;
    logic [11:0]   iEdge;
    logic          iEdgeDVAL;
    logic [1:0]    oMode;
    logic [1:0]    oPendMode;
    logic [CW-1:0] oEdgeCount;
    logic          oFrameDone;
    logic          oInFrame;

    int n_tests = 0;
    int n_fail  = 0;

    // Stimulus state shared by the tasks.
    logic        key_lvl;
    logic [11:0] pixq[$];

    // Reference model state.
    int m_mode, m_pend, m_pub, m_cnt;
    int m_k1, m_k2, m_acc, m_run;
    bit m_done, m_inframe, m_armed, m_fvd, m_press_due;

    sobel_frame_ctrl #(
        .DEBOUNCE_CYC (DEB),
        .CNT_W        (CW)
    ) dut (
        .iCLK       (iCLK),
        .iRST       (iRST),
        .iKEY_n     (iKEY_n),
        .iFVAL      (iFVAL),
        .iEdge      (iEdge),
        .iEdgeDVAL  (iEdgeDVAL),
        .oMode      (oMode),
        .oPendMode  (oPendMode),
        .oEdgeCount (oEdgeCount),
        .oFrameDone (oFrameDone),
        .oInFrame   (oInFrame)
    );

    always #5 iCLK = ~iCLK;

    // Hard stop so a stuck run still reports.
    initial begin
        #2ms;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected finish");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input int observed, input int expected);
        n_tests++;
        if (observed != expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    task automatic checkAll(input string tag);
        checkOutput({tag, ".mode"},  int'(oMode),      m_mode);
        checkOutput({tag, ".pend"},  int'(oPendMode),  m_pend);
        checkOutput({tag, ".count"}, int'(oEdgeCount), m_pub);
        checkOutput({tag, ".done"},  int'(oFrameDone), int'(m_done));
        checkOutput({tag, ".infr"},  int'(oInFrame),   int'(m_inframe));
    endtask

    task automatic modelReset();
        m_mode = 0; m_pend = 0; m_pub = 0; m_cnt = 0;
        m_k1 = 1; m_k2 = 1; m_acc = 1; m_run = 0;
        m_done = 0; m_inframe = 0; m_armed = 0; m_fvd = 0; m_press_due = 0;
    endtask

    // Advances the model across one rising edge with the given inputs.
    task automatic modelStep(input bit fval, input int pix, input bit dval);
        int  sample;
        int  old_pend;
        bit  rise;
        bit  fall;

        // Key: two-stage delay, then a run of DEB samples away from the
        // accepted level; a press shows on the pending mode one edge later.
        old_pend = m_pend;
        if (m_press_due) m_pend = (m_pend + 1) % 3;
        m_press_due = 0;
        sample = m_k2;
        m_k2 = m_k1;
        m_k1 = int'(key_lvl);
        if (sample == m_acc) begin
            m_run = 0;
        end else begin
            m_run++;
            if (m_run == DEB) begin
                m_acc = sample;
                m_run = 0;
                if (sample == 0) m_press_due = 1;
            end
        end

        // Frames: tally nonzero valid pixels, publish clipped to SAT.
        rise = fval && !m_fvd;
        fall = !fval && m_fvd;
        m_done = 0;
        if (!m_armed) begin
            if (!fval) m_armed = 1;
        end else if (!m_inframe) begin
            if (rise) begin
                m_inframe = 1;
                m_mode = old_pend;
                m_cnt = 0;
            end
        end else begin
            if (dval && pix != 0) m_cnt++;
            if (fall) begin
                m_inframe = 0;
                m_pub = (m_cnt > SAT) ? SAT : m_cnt;
                m_done = 1;
            end
        end
        m_fvd = fval;
    endtask

    // Called at a falling edge: check, drive, advance, wait a cycle.
    task automatic applyStimulus(input bit fval, input int pix, input bit dval);
        checkAll("cyc");
        iKEY_n    = key_lvl;
        iFVAL     = fval;
        iEdge     = 12'(pix);
        iEdgeDVAL = dval;
        modelStep(fval, pix, dval);
        @(negedge iCLK);
    endtask

    task automatic doReset();
        iRST = 1'b0;
        modelReset();
        #1;
        checkAll("rst");
        @(negedge iCLK);
        @(negedge iCLK);
        iRST = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 0, 1'b0);
    endtask

    task automatic runFrame(input bit fall_hit);
        applyStimulus(1'b1, 0, 1'b0);
        for (int i = 0; i < pixq.size(); i++) applyStimulus(1'b1, int'(pixq[i]), 1'b1);
        if (fall_hit) applyStimulus(1'b0, 9, 1'b1);
        else          applyStimulus(1'b0, 0, 1'b0);
    endtask

    task automatic press();
        key_lvl = 1'b0;
        idle(8);
        key_lvl = 1'b1;
        idle(8);
    endtask

    initial begin
        int exp_pend[3];
        exp_pend[0] = 2; exp_pend[1] = 0; exp_pend[2] = 1;

        iRST = 1'b0; key_lvl = 1'b1; iKEY_n = 1'b1;
        iFVAL = 1'b1; iEdge = '0; iEdgeDVAL = 1'b0;
        modelReset();
        @(negedge iCLK);

        // 1: reset inside a frame; the partial frame must not publish.
        doReset();
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, i + 1, 1'b1);
        applyStimulus(1'b0, 0, 1'b0);
        checkOutput("t1_done", int'(oFrameDone), 0);
        checkOutput("t1_count", int'(oEdgeCount), 0);
        idle(3);
        checkOutput("t1_infr", int'(oInFrame), 0);

        // 2: one full frame, count of nonzero pixels.
        pixq = '{12'd0, 12'd5, 12'd0, 12'd7, 12'd1, 12'd0, 12'd0, 12'd3};
        runFrame(1'b0);
        checkOutput("t2_done", int'(oFrameDone), 1);
        checkOutput("t2_count", int'(oEdgeCount), 4);
        idle(1);
        checkOutput("t2_pulse_once", int'(oFrameDone), 0);
        idle(2);

        // 3: short bounce ignored, then full presses step the mode.
        key_lvl = 1'b0; idle(3);
        key_lvl = 1'b1; idle(10);
        checkOutput("t3_bounce", int'(oPendMode), 0);
        key_lvl = 1'b0; idle(10);
        key_lvl = 1'b1; idle(10);
        checkOutput("t3_press1", int'(oPendMode), 1);
        for (int i = 0; i < 3; i++) begin
            press();
            checkOutput("t3_step", int'(oPendMode), exp_pend[i]);
        end

        // 4a: press during a frame commits only at the next frame start.
        applyStimulus(1'b1, 0, 1'b0);
        checkOutput("t4_commit", int'(oMode), 1);
        key_lvl = 1'b0;
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1, 1'b1);
        key_lvl = 1'b1;
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1, 1'b1);
        applyStimulus(1'b0, 0, 1'b0);
        checkOutput("t4_hold_mode", int'(oMode), 1);
        checkOutput("t4_pend", int'(oPendMode), 2);
        checkOutput("t4_count", int'(oEdgeCount), 14 > SAT ? SAT : 14);
        idle(8);
        pixq = '{12'd2, 12'd0};
        runFrame(1'b0);
        checkOutput("t4_next_mode", int'(oMode), 2);
        idle(8);

        // 4b: press accepted on the rise cycle is deferred a frame.
        key_lvl = 1'b0;
        idle(6);
        applyStimulus(1'b1, 0, 1'b0);
        checkOutput("t4_rise_mode", int'(oMode), 2);
        checkOutput("t4_rise_pend", int'(oPendMode), 0);
        key_lvl = 1'b1;
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 3, 1'b1);
        applyStimulus(1'b0, 0, 1'b0);
        idle(8);
        pixq = '{12'd1};
        runFrame(1'b1);
        checkOutput("t4_deferred", int'(oMode), 0);
        checkOutput("t4_fall_pix", int'(oEdgeCount), 2);
        idle(2);

        // 5: saturation.
        pixq.delete();
        for (int i = 0; i < 20; i++) pixq.push_back(12'(i + 1));
        runFrame(1'b0);
        checkOutput("t5_sat", int'(oEdgeCount), 15);
        idle(2);

        // Zero-length frame.
        pixq.delete();
        runFrame(1'b0);
        checkOutput("zl_done", int'(oFrameDone), 1);
        checkOutput("zl_count", int'(oEdgeCount), 0);
        idle(2);

        // 6: reset mid-frame at count 6.
        applyStimulus(1'b1, 0, 1'b0);
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 8, 1'b1);
        doReset();
        checkOutput("t6_mode", int'(oMode), 0);
        checkOutput("t6_count", int'(oEdgeCount), 0);
        checkOutput("t6_infr", int'(oInFrame), 0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 5, 1'b1);
        applyStimulus(1'b0, 0, 1'b0);
        checkOutput("t6_partial", int'(oFrameDone), 0);
        idle(3);
        pixq = '{12'd4, 12'd0, 12'd9};
        runFrame(1'b0);
        checkOutput("t6_full", int'(oEdgeCount), 2);
        idle(2);

        // Randomized frames, pixels and key activity.
        for (int f = 0; f < 40; f++) begin
            int blank_len;
            int frame_len;
            blank_len = $urandom_range(1, 6);
            frame_len = $urandom_range(0, 22);
            for (int c = 0; c < blank_len + frame_len + 2; c++) begin
                bit fv;
                int pix;
                if ($urandom_range(0, 7) == 0) key_lvl = ~key_lvl;
                fv  = (c >= blank_len) && (c < blank_len + frame_len + 1);
                pix = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 4095));
                applyStimulus(fv, pix, $urandom_range(0, 3) != 0);
            end
        end
        checkAll("final");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
